mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 2:1 gate-level mux between two requesters (A, B).
//   Drives the mux select and one grant per requester. Break-before-make on owner change.
//   Bounds tenure with a hold counter so neither side starves.
//   Sits beside the mux2to1 instance; sel feeds the mux seletor (0 = A, 1 = B).
// PARAMETERS
//   MAX_HOLD  8  max consecutive granted cycles while the other side waits; legal range >= 2
//   CNT_W     4  hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   req_a     in   1      requester A wants the mux; level, held until granted or withdrawn
//   req_b     in   1      requester B wants the mux
//   done_a    in   1      A releases ownership (1-cycle pulse; ignored unless gnt_a=1)
//   done_b    in   1      B releases ownership (ignored unless gnt_b=1)
//   gnt_a     out  1      A owns the mux output
//   gnt_b     out  1      B owns the mux output
//   sel       out  1      mux select: 0 = input A, 1 = input B
//   busy      out  1      1 in any state except IDLE
//   hold_cnt  out  CNT_W  cycles the current owner has held the grant; saturates at MAX_HOLD-1
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, gnt_a=gnt_b=0, sel=0, busy=0, hold_cnt=0, last_owner=B.
//     - last_owner=B means A wins the first tie.
//   All outputs are registered. gnt_a and gnt_b are never 1 together.
//   States:
//     - IDLE: no grant; sel holds its last value.
//     - GNT_A: gnt_a=1, sel=0.
//     - GNT_B: gnt_b=1, sel=1.
//     - SWITCH: one dead cycle, both grants 0, sel already points to the next owner.
//   IDLE:
//     - Only req_x sampled -> GNT_x next edge. Latency 1 cycle; sel and gnt_x update on the same edge.
//     - Both requests -> grant the side that is not last_owner.
//   GNT_x, release:
//     - done_x=1 or req_x=0 ends tenure; last_owner<=x.
//     - Other side requesting -> SWITCH; else -> IDLE.
//   GNT_x, preempt:
//     - hold_cnt==MAX_HOLD-1 and other side requesting -> SWITCH; last_owner<=x.
//     - Other side not requesting -> stay; hold_cnt saturates.
//   SWITCH:
//     - Next edge grants the side sel points to, if it is still requesting; else -> IDLE.
//     - New grant arrives 2 cycles after the release or preempt edge.
//   hold_cnt:
//     - Cleared on entry to every GNT state and in IDLE/SWITCH.
//     - +1 per cycle in a GNT state.
//   Simultaneous events:
//     - done_x and preempt in the same cycle -> treated as a release (same SWITCH path).
//     - done from a non-owner is ignored.
//     - req_x rising in the same cycle as the owner's done -> SWITCH.
//   Reset mid-tenure immediately drops both grants (async). sel returns to 0.
// STRUCTURE
//   Shared include mux_arb_defs.vh:
//     - state encodings IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2, SWITCH=2'd3
//     - SEL_A=1'b0, SEL_B=1'b1
//   Sub-module hold_counter (clear, enable, saturating at MAX_HOLD-1; outputs count and at_max).
//   The arbiter does not instantiate mux2to1. Integration wires sel to the mux.
// TESTING
//   1. Reset, req_a=1 only -> gnt_a=1, sel=0, busy=1 one edge later; gnt_b stays 0.
//   2. IDLE, req_a=req_b=1 same cycle after reset -> gnt_a first.
//      - done_a pulse -> SWITCH (both grants 0, sel=1) -> gnt_b next edge.
//   3. Preempt: A granted, req_a held, req_b=1 at cycle 0 of tenure (MAX_HOLD=8).
//      - gnt_a drops after 8 granted cycles, SWITCH, gnt_b asserts; hold_cnt seen 0..7.
//   4. Saturation: A granted alone for 20 cycles -> hold_cnt stays 7, gnt_a stays 1.
//      - req_b then rises -> SWITCH on the next edge.
//   5. Withdrawal: in SWITCH toward B, req_b drops -> IDLE; no grant; sel stays 1.
//      - done_b while gnt_a=1 -> no effect.
//   6. rst_n low mid-GNT_B, asynchronous to clk -> gnt_b=0, sel=0, hold_cnt=0 before the next edge.
//      - After release, req_a=req_b=1 -> A granted first.
//   Checkers throughout: assert !(gnt_a && gnt_b), and assert sel matches the owner whenever a grant is high.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants for the mux select arbiter: FSM state encodings and
// mux select values. Imported by the arbiter and its hold counter.
package mux_sel_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_A  = 2'd1;
  localparam logic [1:0] ST_GNT_B  = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_hold.sv
// Saturating tenure counter for the mux select arbiter.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : force count to zero (wins over enable)
//   enable_i    : count up by one, stopping at MAX_HOLD-1
//   count_o     : current count
//   at_max_o    : count has reached MAX_HOLD-1
module mux_sel_arbiter_hold
  import mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign at_max_o = (count_q == CNT_MAX);
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i && !at_max_o)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter sharing a 2:1 mux between requesters A and B.
// Break-before-make: an owner change always passes through one dead cycle
// with both grants low. Tenure is bounded by a saturating hold counter.
//   clk, rst_n      : clock, async active-low reset
//   req_a, req_b    : level requests
//   done_a, done_b  : release pulses, honoured only from the current owner
//   gnt_a, gnt_b    : registered grants, never both high
//   sel             : mux select, 0 = A, 1 = B
//   busy            : high in any state other than IDLE
//   hold_cnt        : cycles the current owner has held the grant
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | no grant, sel keeps its last value
// GNT_A     | A owns the mux, sel = 0
// GNT_B     | B owns the mux, sel = 1
// SWITCH    | dead cycle, both grants low, sel already at next owner
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             done_a,
  input  logic             done_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  logic [1:0] state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       gnt_a_q, gnt_b_q, busy_q;
  logic       cnt_en, at_max;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not own the mux last wins.
        if (req_a && (!req_b || last_q == SEL_B)) begin
          state_d = ST_GNT_A;
          sel_d   = SEL_A;
        end else if (req_b) begin
          state_d = ST_GNT_B;
          sel_d   = SEL_B;
        end
      end
      ST_GNT_A: begin
        // Release and preempt share one exit path.
        if (done_a || !req_a || (at_max && req_b)) begin
          last_d = SEL_A;
          if (req_b) begin
            state_d = ST_SWITCH;
            sel_d   = SEL_B;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GNT_B: begin
        if (done_b || !req_b || (at_max && req_a)) begin
          last_d = SEL_B;
          if (req_a) begin
            state_d = ST_SWITCH;
            sel_d   = SEL_A;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SWITCH: begin
        if (sel_q == SEL_B) state_d = req_b ? ST_GNT_B : ST_IDLE;
        else                state_d = req_a ? ST_GNT_A : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counting only while staying in the same grant state; every entry to a
  // grant state, and all non-grant states, see a cleared count.
  assign cnt_en = (state_q == ST_GNT_A && state_d == ST_GNT_A) ||
                  (state_q == ST_GNT_B && state_d == ST_GNT_B);

  mux_sel_arbiter_hold #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!cnt_en),
    .enable_i (cnt_en),
    .count_o  (hold_cnt),
    .at_max_o (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_a_q <= (state_d == ST_GNT_A);
      gnt_b_q <= (state_d == ST_GNT_B);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0, req_b = 1'b0, done_a = 1'b0, done_b = 1'b0;
  logic             gnt_a, gnt_b, sel, busy;
  logic [CNT_W-1:0] hold_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .done_a   (done_a),
    .done_b   (done_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: who owns the mux, whether a dead cycle is pending, tenure length.
  bit m_has;   // someone owns the mux
  bit m_who;   // owner: 0 = A, 1 = B
  bit m_gap;   // dead cycle in progress toward m_sel
  bit m_sel;
  bit m_last;
  int m_ten;

  always @(posedge clk or negedge rst_n) begin
    bit rq[2];
    bit dn[2];
    if (!rst_n) begin
      m_has = 0; m_who = 0; m_gap = 0; m_sel = 0; m_last = 1; m_ten = 0;
    end else begin
      rq[0] = req_a; rq[1] = req_b; dn[0] = done_a; dn[1] = done_b;
      if (m_gap) begin
        m_gap = 0;
        if (rq[m_sel]) begin m_has = 1; m_who = m_sel; m_ten = 0; end
      end else if (m_has) begin
        bit w, o;
        w = m_who; o = !m_who;
        if (dn[w] || !rq[w] || (m_ten >= MAX_HOLD - 1 && rq[o])) begin
          m_last = w; m_has = 0; m_ten = 0;
          if (rq[o]) begin m_gap = 1; m_sel = o; end
        end else begin
          m_ten = (m_ten + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_ten + 1;
        end
      end else if (rq[0] || rq[1]) begin
        bit p;
        if (rq[0] && rq[1]) p = !m_last;
        else                p = rq[1];
        m_has = 1; m_who = p; m_sel = p; m_ten = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_gnt_a", gnt_a, m_has && !m_who);
      chk("m_gnt_b", gnt_b, m_has && m_who);
      chk("m_sel", sel, m_has ? m_who : m_sel);
      chk("m_busy", busy, m_has || m_gap);
      chk("m_hold", hold_cnt, m_has ? m_ten : 0);
      chk("excl_grants", gnt_a && gnt_b, 0);
      if (gnt_a || gnt_b) chk("sel_owner", sel, gnt_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 0; req_b = 0; done_a = 0; done_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", hold_cnt, 0);

    // 1: single request, 1-cycle latency
    req_a = 1; step(1);
    chk("t1_gnt_a", gnt_a, 1);
    chk("t1_gnt_b", gnt_b, 0);
    chk("t1_sel", sel, 0);
    chk("t1_busy", busy, 1);
    req_a = 0; step(1);
    chk("t1_rel", gnt_a, 0);
    chk("t1_idle", busy, 0);

    // 2: tie after reset goes to A; done_a hands over through SWITCH
    do_reset();
    req_a = 1; req_b = 1; step(1);
    chk("t2_first_a", gnt_a, 1);
    step(2);
    chk("t2_hold2", hold_cnt, 2);
    done_a = 1; step(1); done_a = 0;
    chk("t2_sw_ga", gnt_a, 0);
    chk("t2_sw_gb", gnt_b, 0);
    chk("t2_sw_sel", sel, 1);
    chk("t2_sw_busy", busy, 1);
    chk("t2_sw_hold", hold_cnt, 0);
    step(1);
    chk("t2_gnt_b", gnt_b, 1);
    req_a = 0; req_b = 0; step(2);
    chk("t2_idle", busy, 0);
    chk("t2_sel_kept", sel, 1);

    // 3: preempt after MAX_HOLD granted cycles
    req_a = 1; step(1);
    chk("t3_gnt_a", gnt_a, 1);
    req_b = 1;
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("t3_hold_seq", hold_cnt, i);
      chk("t3_gnt_held", gnt_a, 1);
      step(1);
    end
    chk("t3_sw_ga", gnt_a, 0);
    chk("t3_sw_gb", gnt_b, 0);
    chk("t3_sw_sel", sel, 1);
    step(1);
    chk("t3_gnt_b", gnt_b, 1);
    req_a = 0; req_b = 0; step(1);
    chk("t3_idle", busy, 0);

    // 4: saturation with no competitor
    req_a = 1; step(1);
    step(20);
    chk("t4_sat_hold", hold_cnt, MAX_HOLD - 1);
    chk("t4_sat_gnt", gnt_a, 1);
    req_b = 1; step(1);
    chk("t4_sw_ga", gnt_a, 0);
    chk("t4_sw_sel", sel, 1);
    step(1);
    chk("t4_gnt_b", gnt_b, 1);
    req_a = 0; req_b = 0; step(1);

    // 5: non-owner done ignored; req_b rising with done_a; withdrawal in SWITCH
    req_a = 1; step(1);
    chk("t5_gnt_a", gnt_a, 1);
    done_b = 1; step(1); done_b = 0;
    chk("t5_doneb_ign", gnt_a, 1);
    chk("t5_hold1", hold_cnt, 1);
    req_b = 1; done_a = 1; step(1); done_a = 0;
    chk("t5_sw_busy", busy, 1);
    chk("t5_sw_sel", sel, 1);
    req_a = 0; req_b = 0; step(1);
    chk("t5_wd_ga", gnt_a, 0);
    chk("t5_wd_gb", gnt_b, 0);
    chk("t5_wd_busy", busy, 0);
    chk("t5_wd_sel", sel, 1);

    // 6: async reset mid GNT_B
    req_b = 1; step(1);
    chk("t6_gnt_b", gnt_b, 1);
    step(2);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_gb", gnt_b, 0);
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_hold", hold_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1; req_a = 1; req_b = 1;
    step(1);
    chk("t6_tie_a", gnt_a, 1);
    chk("t6_tie_gb", gnt_b, 0);
    req_a = 0; req_b = 0; step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
